// File: rtl/mem_access.sv
// RV32I memory-access stage: ALU result in, req/gnt/rvalid bus for loads and stores,
// aligned/extended result or access exception out to writeback over valid/ready.
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_store_data,
    input  logic        in_mem_en,
    input  logic        in_mem_we,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_we,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic        out_exc,
    output logic [3:0]  out_exc_code,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned   CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic          TO_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    // Unsupported funct3 encodings fall through to the word case.
    function automatic logic [31:0] load_align(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  load_align = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_align = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_align = {24'h00_0000, sh[7:0]};
            3'b101:  load_align = {16'h0000, sh[15:0]};
            default: load_align = sh;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic          bubble_q, bubble_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [4:0]    rd_q, rd_d;
    logic          rd_we_q, rd_we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   odata_q, odata_d;
    logic [4:0]    ord_q, ord_d;
    logic          ord_we_q, ord_we_d;
    logic          oexc_q, oexc_d;
    logic [3:0]    ocode_q, ocode_d;

    logic          in_ready_s, xfer_s, is_byte_s, is_half_s, mis_s, st_ok_s;
    logic [1:0]    off_s;
    logic [31:0]   acc_wdata_s;
    logic [3:0]    acc_wstrb_s;

    // Accept-time decode: size, misalignment and store lane placement.
    always_comb begin
        in_ready_s  = (state_q == IDLE) | ((state_q == DONE) & ~bubble_q & out_ready);
        xfer_s      = in_valid & in_ready_s;
        off_s       = in_alu_result[1:0];
        is_byte_s   = (in_funct3[1:0] == 2'b00);
        is_half_s   = (in_funct3[1:0] == 2'b01);
        mis_s       = (is_half_s & off_s[0]) | (~is_byte_s & ~is_half_s & (off_s != 2'b00));
        st_ok_s     = in_mem_en & in_mem_we & ~mis_s;
        acc_wdata_s = 32'h0000_0000;
        acc_wstrb_s = 4'b0000;
        if (st_ok_s) begin
            if (is_byte_s) begin
                acc_wdata_s = {4{in_store_data[7:0]}};
                acc_wstrb_s = 4'b0001 << off_s;
            end else if (is_half_s) begin
                acc_wdata_s = {2{in_store_data[15:0]}};
                acc_wstrb_s = 4'b0011 << off_s;
            end else begin
                acc_wdata_s = in_store_data;
                acc_wstrb_s = 4'b1111;
            end
        end else begin
            acc_wdata_s = 32'h0000_0000;
            acc_wstrb_s = 4'b0000;
        end
    end

    // Next-state and result capture; out_* registers load only on entry into DONE.
    always_comb begin
        state_d  = state_q;
        bubble_d = 1'b0;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        rd_we_d  = rd_we_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        odata_d  = odata_q;
        ord_d    = ord_q;
        ord_we_d = ord_we_q;
        oexc_d   = oexc_q;
        ocode_d  = ocode_q;
        case (state_q)
            IDLE, DONE: begin
                if (xfer_s) begin
                    addr_d  = in_alu_result;
                    we_d    = in_mem_en & in_mem_we;
                    f3_d    = in_funct3;
                    rd_d    = in_rd;
                    rd_we_d = in_rd_we;
                    wdata_d = acc_wdata_s;
                    wstrb_d = acc_wstrb_s;
                    cnt_d   = '0;
                    if (!in_mem_en) begin
                        state_d  = DONE;
                        bubble_d = (state_q == DONE);
                        odata_d  = in_alu_result;
                        ord_d    = in_rd;
                        ord_we_d = in_rd_we;
                        oexc_d   = 1'b0;
                        ocode_d  = 4'd0;
                    end else if (mis_s) begin
                        state_d  = DONE;
                        bubble_d = (state_q == DONE);
                        odata_d  = in_alu_result;
                        ord_d    = in_rd;
                        ord_we_d = 1'b0;
                        oexc_d   = 1'b1;
                        ocode_d  = in_mem_we ? 4'd6 : 4'd4;
                    end else begin
                        state_d = REQ;
                    end
                end else if ((state_q == DONE) && !bubble_q && out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    cnt_d = '0;
                    if (we_q) begin
                        state_d  = DONE;
                        odata_d  = 32'h0000_0000;
                        ord_d    = rd_q;
                        ord_we_d = 1'b0;
                        oexc_d   = 1'b0;
                        ocode_d  = 4'd0;
                    end else begin
                        state_d = RESP;
                    end
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d  = DONE;
                    odata_d  = addr_q;
                    ord_d    = rd_q;
                    ord_we_d = 1'b0;
                    oexc_d   = 1'b1;
                    ocode_d  = we_q ? 4'd7 : 4'd5;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_d  = DONE;
                    odata_d  = load_align(mem_rdata, addr_q[1:0], f3_q);
                    ord_d    = rd_q;
                    ord_we_d = rd_we_q;
                    oexc_d   = 1'b0;
                    ocode_d  = 4'd0;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d  = DONE;
                    odata_d  = addr_q;
                    ord_d    = rd_q;
                    ord_we_d = 1'b0;
                    oexc_d   = 1'b1;
                    ocode_d  = 4'd5;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bubble_q <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= 32'h0000_0000;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            rd_q     <= 5'd0;
            rd_we_q  <= 1'b0;
            wdata_q  <= 32'h0000_0000;
            wstrb_q  <= 4'b0000;
            odata_q  <= 32'h0000_0000;
            ord_q    <= 5'd0;
            ord_we_q <= 1'b0;
            oexc_q   <= 1'b0;
            ocode_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            bubble_q <= bubble_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            rd_we_q  <= rd_we_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            odata_q  <= odata_d;
            ord_q    <= ord_d;
            ord_we_q <= ord_we_d;
            oexc_q   <= oexc_d;
            ocode_q  <= ocode_d;
        end
    end

    // A quick op accepted while DONE is handshaking parks one cycle with out_valid low.
    assign in_ready     = in_ready_s;
    assign out_valid    = (state_q == DONE) & ~bubble_q;
    assign out_data     = odata_q;
    assign out_rd       = ord_q;
    assign out_rd_we    = ord_we_q;
    assign out_exc      = oexc_q;
    assign out_exc_code = ocode_q;
    assign mem_req      = (state_q == REQ);
    assign mem_addr     = {addr_q[31:2], 2'b00};
    assign mem_we       = we_q;
    assign mem_wdata    = wdata_q;
    assign mem_wstrb    = wstrb_q;

endmodule
